// File: rtl/rx_clk_lane_mon_if.sv
// Clock-lane line inputs and monitor status outputs for rx_clk_lane_mon.
interface rx_clk_lane_mon_if #(
  parameter int CNT_W = 8
);
  logic             CLKDp;
  logic             CLKDn;
  logic             RX_HS_CLK;
  logic             hs_active;
  logic             term_en;
  logic             ulps_active;
  logic             err_ctrl;
  logic [2:0]       lane_state;
  logic [CNT_W-1:0] burst_cnt;

  modport master (
    output CLKDp, CLKDn,
    input  RX_HS_CLK, hs_active, term_en, ulps_active, err_ctrl, lane_state, burst_cnt
  );

  modport slave (
    input  CLKDp, CLKDn,
    output RX_HS_CLK, hs_active, term_en, ulps_active, err_ctrl, lane_state, burst_cnt
  );
endinterface

// File: rtl/rx_clk_lane_mon.sv
// Receive-side clock-lane monitor: tracks LP/HS/ULPS line states,
// gates the HS clock, flags protocol errors and counts completed bursts.
module rx_clk_lane_mon #(
  parameter int Tclk_term_en = 2,
  parameter int Tclk_settle  = 4,
  parameter int Tclk_miss    = 4,
  parameter int ULPS_EN      = 1,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  rx_clk_lane_mon_if.slave   lane
);
  // HS_CLK needs a ninth state; it is reported on lane_state as HS_TERM's code
  // (hs_active tells the two apart).
  typedef enum logic [3:0] {
    ST_STOP      = 4'd0,
    ST_HS_RQST   = 4'd1,
    ST_HS_PRPR   = 4'd2,
    ST_HS_TERM   = 4'd3,
    ST_ERR       = 4'd4,
    ST_ULPS_RQST = 4'd5,
    ST_ULPS      = 4'd6,
    ST_ULPS_EXIT = 4'd7,
    ST_HS_CLK    = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] T_TE = CNT_W'(Tclk_term_en);
  localparam logic [CNT_W-1:0] T_TS = CNT_W'(Tclk_settle);
  localparam logic [CNT_W-1:0] T_TM = CNT_W'(Tclk_miss);

  state_t           state, state_nx;
  logic [1:0]       ls, ls_prev;
  logic [CNT_W-1:0] tmr, tmr_nx, tmr_inc;
  logic [CNT_W-1:0] burst_q;
  logic             burst_inc;
  logic             err_q;
  logic             toggle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_STOP;
      ls      <= 2'b11;
      ls_prev <= 2'b11;
      tmr     <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ls      <= {lane.CLKDp, lane.CLKDn};
      ls_prev <= ls;
      tmr     <= tmr_nx;
      err_q   <= (state_nx == ST_ERR) && (state != ST_ERR);
      if (burst_inc && (burst_q != '1)) burst_q <= burst_q + 1'b1;
    end
  end

  assign tmr_inc = tmr + 1'b1;
  assign toggle  = (ls == 2'b01 || ls == 2'b10) && (ls != ls_prev);

  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr;
    burst_inc = 1'b0;
    case (state)
      ST_STOP: case (ls)
        2'b01:   state_nx = ST_HS_RQST;
        2'b10:   state_nx = (ULPS_EN != 0) ? ST_ULPS_RQST : ST_ERR;
        2'b00:   state_nx = ST_ERR;
        default: state_nx = ST_STOP;
      endcase
      ST_HS_RQST: case (ls)
        2'b00:   state_nx = ST_HS_PRPR;
        2'b11:   state_nx = ST_STOP;
        2'b10:   state_nx = ST_ERR;
        default: state_nx = ST_HS_RQST;
      endcase
      ST_HS_PRPR: begin
        if (ls == 2'b11)      state_nx = ST_STOP;
        else if (ls == 2'b00) begin
          if (tmr_inc == T_TE) state_nx = ST_HS_TERM;
          else                 tmr_nx   = tmr_inc;
        end else              state_nx = ST_ERR;
      end
      ST_HS_TERM: begin
        if (ls == 2'b11)          state_nx = ST_STOP;
        else if (tmr_inc == T_TS) state_nx = ST_HS_CLK;
        else                      tmr_nx   = tmr_inc;
      end
      ST_HS_CLK: begin
        // end-of-burst wins over a miss landing on the same cycle
        if (ls == 2'b11) begin
          state_nx  = ST_STOP;
          burst_inc = 1'b1;
        end else if (toggle)      tmr_nx   = '0;
        else if (tmr_inc == T_TM) state_nx = ST_ERR;
        else                      tmr_nx   = tmr_inc;
      end
      ST_ULPS_RQST: case (ls)
        2'b00:   state_nx = ST_ULPS;
        2'b11:   state_nx = ST_STOP;
        2'b01:   state_nx = ST_ERR;
        default: state_nx = ST_ULPS_RQST;
      endcase
      ST_ULPS: case (ls)
        2'b10:   state_nx = ST_ULPS_EXIT;
        2'b00:   state_nx = ST_ULPS;
        default: state_nx = ST_ERR;
      endcase
      ST_ULPS_EXIT: case (ls)
        2'b11:   state_nx = ST_STOP;
        2'b00:   state_nx = ST_ULPS;
        2'b01:   state_nx = ST_ERR;
        default: state_nx = ST_ULPS_EXIT;
      endcase
      ST_ERR:  state_nx = (ls == 2'b11) ? ST_STOP : ST_ERR;
      default: state_nx = ST_STOP;
    endcase
    if (state_nx != state) tmr_nx = '0;
  end

  always_comb begin
    lane.hs_active   = (state == ST_HS_CLK);
    lane.term_en     = (state == ST_HS_TERM) || (state == ST_HS_CLK);
    lane.ulps_active = (state == ST_ULPS) || (state == ST_ULPS_EXIT);
    lane.err_ctrl    = err_q;
    lane.burst_cnt   = burst_q;
    lane.lane_state  = (state == ST_HS_CLK) ? 3'd3 : state[2:0];
    lane.RX_HS_CLK   = lane.CLKDp & (state == ST_HS_CLK);
  end
endmodule
